rtc_multi_alarm: RTL and testbench

- Memory-mapped real-time clock peripheral on the MCU APB-style slave bus. Successor to the single-counter RTC.
- Adds a parametrised clock-to-second prescaler, a 24 h hour/min/sec counter with software load, and NUM_ALARMS independent alarm comparators.
- Alarms have sticky pending bits and a maskable interrupt line into the core's interrupt input.

---
 rtl/rtc_pkg.sv | 45 ++++
 rtl/rtc_alarm_cmp.sv | 30 +++
 rtl/rtc_multi_alarm.sv | 163 ++++++++++++++++
 tb/tb_rtc_multi_alarm.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared constants for the multi-alarm RTC: register offsets, time-field
// layout and limits, plus a helper that packs hour/min/sec into register form.
package rtc_pkg;

    localparam int OFF_CTRL   = 'h00;
    localparam int OFF_TIME   = 'h04;
    localparam int OFF_STATUS = 'h08;
    localparam int OFF_ALARM0 = 'h0C;

    localparam int WIDX_CTRL   = OFF_CTRL / 4;
    localparam int WIDX_TIME   = OFF_TIME / 4;
    localparam int WIDX_STATUS = OFF_STATUS / 4;
    localparam int WIDX_ALARM0 = OFF_ALARM0 / 4;

    localparam int SEC_LSB  = 0;
    localparam int SEC_W    = 6;
    localparam int MIN_LSB  = 8;
    localparam int MIN_W    = 6;
    localparam int HOUR_LSB = 16;
    localparam int HOUR_W   = 5;

    localparam int CTRL_RUN_BIT = 0;
    localparam int CTRL_IRQ_LSB = 4;
    localparam int ALM_EN_BIT   = 31;
    localparam int MAX_ALARMS   = 4;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    localparam logic [31:0] TIME_MASK  = 32'h001F_3F3F;
    localparam logic [31:0] ALARM_MASK = 32'h801F_3F3F;

    function automatic logic [31:0] pack_time(input logic [HOUR_W-1:0] h,
                                              input logic [MIN_W-1:0]  m,
                                              input logic [SEC_W-1:0]  s);
        logic [31:0] t;
        t = '0;
        t[HOUR_LSB +: HOUR_W] = h;
        t[MIN_LSB  +: MIN_W]  = m;
        t[SEC_LSB  +: SEC_W]  = s;
        return t;
    endfunction

endpackage

// File: rtl/rtc_alarm_cmp.sv
// One alarm channel: compares the post-tick time with its alarm register and
// holds a sticky pending flag that software clears by writing 1.
module rtc_alarm_cmp
    import rtc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alarm,
    input  logic [31:0] next_time,
    input  logic        tick,
    input  logic        clr,
    output logic        pending
);

    logic hit;

    assign hit = tick & alarm[ALM_EN_BIT] & ((alarm & TIME_MASK) == next_time);

    // A match on the same edge as a software clear keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
        end else if (hit) begin
            pending <= 1'b1;
        end else if (clr) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/rtc_multi_alarm.sv
// Real-time clock slave: prescaler, 24 h hh:mm:ss counter with software load,
// NUM_ALARMS alarm channels with sticky pending bits and a maskable irq.
module rtc_multi_alarm
    import rtc_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int NUM_ALARMS = 2,
    parameter int ADDR_W     = 5
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              sec_tick,
    output logic              irq
);

    localparam int            PW         = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0]         presc;
    logic                  run;
    logic [NUM_ALARMS-1:0] irq_en;
    logic [NUM_ALARMS-1:0] pending;
    logic [NUM_ALARMS-1:0] clr;
    logic [NUM_ALARMS-1:0] alarm_we;
    logic [31:0]           alarm_q [NUM_ALARMS];

    logic [SEC_W-1:0]  sec_q,  sec_nxt,  sec_ld;
    logic [MIN_W-1:0]  min_q,  min_nxt,  min_ld;
    logic [HOUR_W-1:0] hour_q, hour_nxt, hour_ld;
    logic [31:0]       next_time;

    logic [31:0] widx;
    logic        bus_we, ctrl_we, time_we, status_we;
    logic        tick;
    logic [1:0]  unused_addr_lsb;

    // Bus: no handshake. A write commits on any rising edge with cs&wr high;
    // reads are combinational from cs/addr and carry no wait states.
    assign unused_addr_lsb = addr[1:0];
    assign widx      = 32'(addr[ADDR_W-1:2]);
    assign bus_we    = cs & wr;
    assign ctrl_we   = bus_we && (widx == 32'(WIDX_CTRL));
    assign time_we   = bus_we && (widx == 32'(WIDX_TIME));
    assign status_we = bus_we && (widx == 32'(WIDX_STATUS));

    always_comb begin
        alarm_we = '0;
        clr      = '0;
        for (int k = 0; k < NUM_ALARMS; k++) begin
            alarm_we[k] = bus_we && (widx == 32'(WIDX_ALARM0 + k));
            clr[k]      = status_we & wdata[k];
        end
    end

    assign tick     = run && (presc == PRESC_LAST);
    assign sec_tick = tick;

    always_comb begin
        sec_nxt  = sec_q + SEC_W'(1);
        min_nxt  = min_q;
        hour_nxt = hour_q;
        if (sec_q >= SEC_MAX) begin
            sec_nxt = '0;
            min_nxt = min_q + MIN_W'(1);
            if (min_q >= MIN_MAX) begin
                min_nxt  = '0;
                hour_nxt = (hour_q >= HOUR_MAX) ? '0 : hour_q + HOUR_W'(1);
            end
        end
    end

    assign next_time = pack_time(hour_nxt, min_nxt, sec_nxt);

    // Loaded values are clamped so the counter never leaves the legal range.
    always_comb begin
        sec_ld  = wdata[SEC_LSB +: SEC_W];
        min_ld  = wdata[MIN_LSB +: MIN_W];
        hour_ld = wdata[HOUR_LSB +: HOUR_W];
        if (sec_ld > SEC_MAX)   sec_ld  = SEC_MAX;
        if (min_ld > MIN_MAX)   min_ld  = MIN_MAX;
        if (hour_ld > HOUR_MAX) hour_ld = HOUR_MAX;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc  <= '0;
            run    <= 1'b0;
            irq_en <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
            for (int k = 0; k < NUM_ALARMS; k++) begin
                alarm_q[k] <= '0;
            end
        end else begin
            if (ctrl_we) begin
                run    <= wdata[CTRL_RUN_BIT];
                irq_en <= wdata[CTRL_IRQ_LSB +: NUM_ALARMS];
            end
            // A load overrides a coincident tick; that second is simply lost.
            if (time_we) begin
                presc  <= '0;
                sec_q  <= sec_ld;
                min_q  <= min_ld;
                hour_q <= hour_ld;
            end else if (run) begin
                if (tick) begin
                    presc  <= '0;
                    sec_q  <= sec_nxt;
                    min_q  <= min_nxt;
                    hour_q <= hour_nxt;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
            for (int k = 0; k < NUM_ALARMS; k++) begin
                if (alarm_we[k]) begin
                    alarm_q[k] <= wdata & ALARM_MASK;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_alarm
        rtc_alarm_cmp u_cmp (
            .clk       (clk),
            .reset     (reset),
            .alarm     (alarm_q[k]),
            .next_time (next_time),
            .tick      (tick & ~time_we),
            .clr       (clr[k]),
            .pending   (pending[k])
        );
    end

    assign irq = |(pending & irq_en);

    always_comb begin
        rdata = '0;
        if (cs) begin
            if (widx == 32'(WIDX_CTRL)) begin
                rdata[CTRL_RUN_BIT]                = run;
                rdata[CTRL_IRQ_LSB +: NUM_ALARMS] = irq_en;
            end else if (widx == 32'(WIDX_TIME)) begin
                rdata = pack_time(hour_q, min_q, sec_q);
            end else if (widx == 32'(WIDX_STATUS)) begin
                rdata[NUM_ALARMS-1:0] = pending;
            end
            for (int k = 0; k < NUM_ALARMS; k++) begin
                if (widx == 32'(WIDX_ALARM0 + k)) begin
                    rdata = alarm_q[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_rtc_multi_alarm.sv
// Bench for rtc_multi_alarm: seconds-of-day reference model, per-cycle compare
// of sec_tick/irq, directed register scenarios with literal expectations.
module tb_rtc_multi_alarm;

    localparam int CLK_HZ = 10;
    localparam int DAY    = 86400;

    logic        clk;
    logic        reset;
    logic        cs, wr;
    logic [4:0]  addr;
    logic [31:0] wdata, rdata;
    logic        sec_tick, irq;
    logic        cs1, wr1;
    logic [4:0]  addr1;
    logic [31:0] wdata1, rdata1;
    logic        tick1, irq1;

    int n_cmp;
    int n_bad;

    rtc_multi_alarm #(.CLK_HZ(CLK_HZ), .NUM_ALARMS(2), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .cs(cs), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .sec_tick(sec_tick), .irq(irq)
    );

    rtc_multi_alarm #(.CLK_HZ(CLK_HZ), .NUM_ALARMS(1), .ADDR_W(5)) dut1 (
        .clk(clk), .reset(reset), .cs(cs1), .wr(wr1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .sec_tick(tick1), .irq(irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (main instance only) ----------------
    int          m_secs;
    int          m_cnt;
    bit          m_run;
    bit [1:0]    m_en;
    bit [1:0]    m_pend;
    logic [31:0] m_alm [2];

    function automatic int cur_idx();
        return int'(addr[4:2]);
    endfunction

    function automatic bit we_at(input int idx);
        return cs && wr && (cur_idx() == idx);
    endfunction

    function automatic bit m_tick();
        return m_run && (m_cnt == CLK_HZ - 1);
    endfunction

    function automatic int load_secs(input logic [31:0] v);
        int h = int'(v[20:16]);
        int m = int'(v[13:8]);
        int s = int'(v[5:0]);
        if (h > 23) h = 23;
        if (m > 59) m = 59;
        if (s > 59) s = 59;
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic int alarm_secs(input logic [31:0] v);
        int h = int'(v[20:16]);
        int m = int'(v[13:8]);
        int s = int'(v[5:0]);
        if (h > 23 || m > 59 || s > 59) return -1;
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic bit alarm_hit(input int k);
        return m_tick() && !we_at(1) && m_alm[k][31] &&
               (alarm_secs(m_alm[k]) == (m_secs + 1) % DAY);
    endfunction

    function automatic logic [31:0] secs_to_reg(input int t);
        return 32'(((t / 3600) << 16) | (((t / 60) % 60) << 8) | (t % 60));
    endfunction

    function automatic logic [31:0] exp_reg(input int idx);
        case (idx)
            0:       return 32'(m_run) | (32'(m_en) << 4);
            1:       return secs_to_reg(m_secs);
            2:       return 32'(m_pend);
            3:       return m_alm[0];
            4:       return m_alm[1];
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_secs   <= 0;
            m_cnt    <= 0;
            m_run    <= 1'b0;
            m_en     <= '0;
            m_pend   <= '0;
            m_alm[0] <= '0;
            m_alm[1] <= '0;
        end else begin
            if (we_at(0)) begin
                m_run <= wdata[0];
                m_en  <= wdata[5:4];
            end
            if (we_at(1)) begin
                m_secs <= load_secs(wdata);
                m_cnt  <= 0;
            end else if (m_run) begin
                m_cnt <= m_tick() ? 0 : m_cnt + 1;
                if (m_tick()) m_secs <= (m_secs + 1) % DAY;
            end
            for (int k = 0; k < 2; k++) begin
                if (we_at(3 + k)) m_alm[k] <= wdata & 32'h801F_3F3F;
                m_pend[k] <= alarm_hit(k) || (m_pend[k] && !(we_at(2) && wdata[k]));
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("sec_tick", 32'(sec_tick), 32'(m_tick()));
            check("irq", 32'(irq), 32'(|(m_pend & m_en)));
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic bus_write(input bit sel, input logic [4:0] a, input logic [31:0] d);
        if (sel) begin cs1 = 1; wr1 = 1; addr1 = a; wdata1 = d; end
        else     begin cs  = 1; wr  = 1; addr  = a; wdata  = d; end
        @(negedge clk);
        cs = 0; wr = 0; cs1 = 0; wr1 = 0;
    endtask

    task automatic read_lit(input bit sel, input logic [4:0] a, input logic [31:0] exp,
                            input string name);
        if (sel) begin cs1 = 1; wr1 = 0; addr1 = a; end
        else     begin cs  = 1; wr  = 0; addr  = a; end
        #1;
        check(name, sel ? rdata1 : rdata, exp);
        cs = 0; cs1 = 0;
    endtask

    task automatic read_mdl(input logic [4:0] a, input string name);
        cs = 1; wr = 0; addr = a;
        #1;
        check(name, rdata, exp_reg(int'(a[4:2])));
        cs = 0;
    endtask

    task automatic wait_tick(input int budget, output bit found, output int n);
        found = 0;
        n     = 0;
        while (!found && n < budget) begin
            @(negedge clk);
            n++;
            if (sec_tick) found = 1;
        end
    endtask

    task automatic need_tick(input int budget, input string name, output int n);
        bit f;
        wait_tick(budget, f, n);
        check(name, 32'(f), 32'h1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        bit f;
        n_cmp = 0; n_bad = 0;
        reset = 0;
        cs = 0; wr = 0; addr = '0; wdata = '0;
        cs1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
        repeat (2) @(negedge clk);
        reset = 1;

        // reset state and run
        read_lit(0, 5'h04, 32'h0, "reset_time");
        read_lit(0, 5'h00, 32'h0, "reset_ctrl");
        check("reset_tick", 32'(sec_tick), 32'h0);
        bus_write(0, 5'h00, 32'h1);
        need_tick(20, "first_tick_seen", n);
        check("first_tick_latency", 32'(n), 32'd9);
        @(negedge clk);
        read_lit(0, 5'h04, 32'h0000_0001, "time_after_first_tick");
        need_tick(20, "second_tick_seen", n);
        check("tick_period", 32'(n + 1), 32'd10);

        // day rollover with alarms disabled (their zero value is 00:00:00)
        bus_write(0, 5'h04, 32'h0017_3B3A);
        read_mdl(5'h04, "time_loaded");
        need_tick(20, "roll_tick1", n);
        need_tick(20, "roll_tick2", n);
        @(negedge clk);
        read_lit(0, 5'h04, 32'h0000_0000, "day_wrap");
        read_lit(0, 5'h08, 32'h0, "no_alarm_when_disabled");

        // alarm interrupt, second channel masked
        bus_write(0, 5'h0C, 32'h8000_0105);
        bus_write(0, 5'h10, 32'h8000_0107);
        bus_write(0, 5'h00, 32'h11);
        bus_write(0, 5'h04, 32'h0000_0103);
        read_mdl(5'h00, "ctrl_readback");
        read_mdl(5'h10, "alarm1_readback");
        need_tick(20, "alm_tick1", n);
        need_tick(20, "alm_tick2", n);
        @(negedge clk);
        read_lit(0, 5'h08, 32'h1, "alarm0_pending");
        check("irq_on_alarm", 32'(irq), 32'h1);
        bus_write(0, 5'h08, 32'h1);
        check("irq_cleared", 32'(irq), 32'h0);
        need_tick(20, "alm_tick3", n);
        need_tick(20, "alm_tick4", n);
        @(negedge clk);
        read_lit(0, 5'h08, 32'h2, "alarm1_pending_masked");
        check("irq_masked", 32'(irq), 32'h0);
        bus_write(0, 5'h08, 32'h3);
        read_mdl(5'h08, "status_cleared");

        // TIME load on the tick edge discards the increment
        need_tick(20, "coll_tick", n);
        bus_write(0, 5'h04, 32'h0005_0A14);
        read_lit(0, 5'h04, 32'h0005_0A14, "load_beats_tick");
        bus_write(0, 5'h0C, 32'h8005_0A15);
        need_tick(20, "coll_tick2", n);
        check("tick_after_load", 32'(n + 2), 32'd10);
        bus_write(0, 5'h08, 32'h1);
        read_lit(0, 5'h08, 32'h1, "set_beats_clear");
        check("irq_after_collision", 32'(irq), 32'h1);
        read_mdl(5'h04, "time_after_collision");

        // asynchronous reset mid-count
        #2 reset = 0;
        #1 check("async_irq", 32'(irq), 32'h0);
        check("async_tick", 32'(sec_tick), 32'h0);
        read_lit(0, 5'h04, 32'h0, "async_time");
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        read_lit(0, 5'h00, 32'h0, "post_reset_ctrl");
        read_lit(0, 5'h08, 32'h0, "post_reset_status");
        wait_tick(15, f, n);
        check("no_tick_when_stopped", 32'(f), 32'h0);

        // map edges and load saturation
        bus_write(0, 5'h14, 32'hFFFF_FFFF);
        read_lit(0, 5'h14, 32'h0, "unmapped_read");
        bus_write(0, 5'h04, 32'h003F_3F3F);
        read_lit(0, 5'h04, 32'h0017_3B3B, "time_saturate");
        read_mdl(5'h0C, "alarm0_after_reset");

        // single-alarm configuration
        bus_write(1, 5'h10, 32'h8000_0001);
        read_lit(1, 5'h10, 32'h0, "n1_alarm1_unmapped");
        bus_write(1, 5'h00, 32'hF1);
        read_lit(1, 5'h00, 32'h11, "n1_ctrl_irq_en_width");
        bus_write(1, 5'h08, 32'hF);
        read_lit(1, 5'h08, 32'h0, "n1_status_width");
        bus_write(1, 5'h04, 32'h001F_3F00);
        read_lit(1, 5'h04, 32'h0017_3B00, "n1_time_saturate");
        check("n1_irq", 32'(irq1), 32'h0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
